hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
Pipeline hazard and stall sequencer for the 5-stage core. It sits beside the forwarding unit.
- Detects load-use hazards that forwarding cannot cover.
- Flushes wrong-path instructions on a taken branch.
- Sequences multi-cycle execute operations (mul/div) by holding them in E for MC_LATENCY cycles.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
MC_LATENCY, 4, number of cycles a multi-cycle op occupies E (legal range 1..15)
CNT_W, 16, width of stall-cycle statistics counter

Ports:
i_clk  input  1  system clock, rising edge
i_rst  input  1  synchronous active-high reset
i_src1_D  input  5  source register 1 of instruction in D
i_src2_D  input  5  source register 2 of instruction in D
i_Write_Reg_E  input  5  destination register of instruction in E
i_MemRead_E  input  1  instruction in E is a load
i_branch_taken_E  input  1  branch in E resolved taken
i_mc_start_E  input  1  instruction in E is a multi-cycle op (held high while it sits in E)
i_clear_stats  input  1  clear stall-cycle counter
o_stall_F  output  1  hold PC / F stage
o_stall_D  output  1  hold F/D register
o_stall_E  output  1  hold D/E register
o_flush_D  output  1  bubble F/D register
o_flush_E  output  1  bubble D/E register
o_flush_M  output  1  bubble E/M register
o_mc_busy  output  1  multi-cycle op in progress
o_mc_done  output  1  multi-cycle result valid this cycle; E/M register captures it
o_stall_cycles  output  CNT_W  saturating count of cycles with o_stall_F=1

Behaviour:
- States: RUN, MC_BUSY. Internal down-counter cnt, width 4. Reset: state=RUN, cnt=0, o_stall_cycles=0.
- While i_rst=1, all control outputs are forced to 0.
- Outputs are combinational from the inputs and the registered state. There is no extra latency.
- Hazard terms (evaluated in RUN only):
  - lu = i_MemRead_E && i_Write_Reg_E!=0 && (i_src1_D==i_Write_Reg_E || i_src2_D==i_Write_Reg_E).
  - br = i_branch_taken_E.
  - mc = i_mc_start_E && MC_LATENCY>1.
- Priority in RUN is br > mc > lu:
  - br: o_flush_D=1, o_flush_E=1. All stalls are 0.
  - mc: o_stall_F=o_stall_D=o_stall_E=1, o_flush_M=1, o_mc_busy=1. Next state is MC_BUSY with cnt=MC_LATENCY-1.
  - lu: o_stall_F=o_stall_D=1, o_flush_E=1 (one bubble). The next cycle the load is in M and forwarding resolves it.
  - none: all outputs 0.
- MC_LATENCY==1: a multi-cycle op behaves as a single-cycle op. o_mc_done=1 whenever i_mc_start_E=1 in RUN. No stall and no state change.
- MC_BUSY:
  - i_mc_start_E, lu and br are ignored. E holds the multi-cycle op, so lu and br cannot legally occur.
  - o_mc_busy=1.
  - If cnt>1: stall F/D/E=1, o_flush_M=1, cnt<=cnt-1.
  - If cnt==1: all stalls and o_flush_M are 0, o_mc_done=1, next state is RUN. The op leaves E at the end of this cycle.
  - Net effect: the op occupies E for exactly MC_LATENCY cycles, with stalls on the first MC_LATENCY-1 of them.
- Back-to-back multi-cycle ops:
  - The RUN cycle after completion sees the new op's i_mc_start_E and restarts the sequence.
  - No dead cycle beyond the one just described.
- When a flush and a stall target the same register, the flush dominates. Only possible in RUN, and priority already excludes it.
- Counter:
  - If i_clear_stats=1: o_stall_cycles<=0. Clear wins over increment.
  - Else if o_stall_F=1 and o_stall_cycles != all-ones: increment.
  - Saturates at 2^CNT_W-1.
- Reset mid-MC_BUSY: the next cycle is RUN with cnt=0. No o_mc_done is produced for the aborted op.

Test Plan:
- Load-use: i_MemRead_E=1, i_Write_Reg_E=5, i_src2_D=5 → same cycle o_stall_F=o_stall_D=o_flush_E=1. Next cycle, with MemRead_E=0, all outputs are 0; o_stall_cycles=1.
- $0 / no match: i_MemRead_E=1, i_Write_Reg_E=0, i_src1_D=0 → no stall. Write_Reg_E=7 with src1_D=6 and src2_D=8 → no stall.
- Branch priority: i_branch_taken_E=1 with a simultaneous lu match → o_flush_D=o_flush_E=1, o_stall_F=0, counter unchanged.
- Multi-cycle, MC_LATENCY=4: i_mc_start_E held high for 4 cycles → stalls and o_flush_M=1 in cycles 1-3, o_mc_done=1 only in cycle 4, o_mc_busy=1 in cycles 1-4, o_stall_cycles=3. A second op in cycle 5 restarts the sequence.
- Reset mid-operation: assert i_rst in cycle 2 of a multi-cycle op → outputs 0 during reset. After release with i_mc_start_E=0, no o_mc_done and state is RUN.
- Counter, CNT_W=4: 20 consecutive lu cycles → o_stall_cycles saturates at 15. i_clear_stats together with a stall → 0.

Source files
------------

// File: rtl/hazard_controller.sv
// Pipeline hazard and stall sequencer: load-use bubbles, taken-branch flushes,
// multi-cycle execute sequencing and a saturating stall-cycle counter.
module hazard_controller #(
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_src1_D,
  input  logic [4:0]       i_src2_D,
  input  logic [4:0]       i_Write_Reg_E,
  input  logic             i_MemRead_E,
  input  logic             i_branch_taken_E,
  input  logic             i_mc_start_E,
  input  logic             i_clear_stats,
  output logic             o_stall_F,
  output logic             o_stall_D,
  output logic             o_stall_E,
  output logic             o_flush_D,
  output logic             o_flush_E,
  output logic             o_flush_M,
  output logic             o_mc_busy,
  output logic             o_mc_done,
  output logic [CNT_W-1:0] o_stall_cycles
);

  typedef enum logic [0:0] {StRun, StMcBusy} state_e;

  localparam bit         McMulti = (MC_LATENCY > 1);
  localparam logic [3:0] CntLoad = 4'(MC_LATENCY - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q;
  logic             lu;

  assign lu = i_MemRead_E && (i_Write_Reg_E != 5'd0) &&
              ((i_src1_D == i_Write_Reg_E) || (i_src2_D == i_Write_Reg_E));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    o_stall_F = 1'b0;
    o_stall_D = 1'b0;
    o_stall_E = 1'b0;
    o_flush_D = 1'b0;
    o_flush_E = 1'b0;
    o_flush_M = 1'b0;
    o_mc_busy = 1'b0;
    o_mc_done = 1'b0;
    if (!i_rst) begin
      unique case (state_q)
        StRun: begin
          // Single-cycle latency: the op completes in place, no sequencing.
          if (!McMulti && i_mc_start_E) o_mc_done = 1'b1;
          if (i_branch_taken_E) begin
            o_flush_D = 1'b1;
            o_flush_E = 1'b1;
          end else if (McMulti && i_mc_start_E) begin
            o_stall_F = 1'b1;
            o_stall_D = 1'b1;
            o_stall_E = 1'b1;
            o_flush_M = 1'b1;
            o_mc_busy = 1'b1;
            state_d   = StMcBusy;
            cnt_d     = CntLoad;
          end else if (lu) begin
            o_stall_F = 1'b1;
            o_stall_D = 1'b1;
            o_flush_E = 1'b1;
          end
        end
        StMcBusy: begin
          o_mc_busy = 1'b1;
          if (cnt_q > 4'd1) begin
            o_stall_F = 1'b1;
            o_stall_D = 1'b1;
            o_stall_E = 1'b1;
            o_flush_M = 1'b1;
            cnt_d     = cnt_q - 4'd1;
          end else begin
            o_mc_done = 1'b1;
            state_d   = StRun;
            cnt_d     = 4'd0;
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StRun;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear_stats) begin
      stall_cycles_q <= '0;
    end else if (o_stall_F && !(&stall_cycles_q)) begin
      stall_cycles_q <= stall_cycles_q + 1'b1;
    end
  end

  assign o_stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: two instances (latency 4 / 16-bit counter and
// latency 1 / 4-bit counter) checked against an occupancy-based model.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst, memrd, br, mcs, clr;
  logic [4:0] src1, src2, wreg;
  logic [1:0] sf, sd, se, fd, fe, fm, busy, done;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int n_chk  = 0;
  int n_fail = 0;

  int m_age [2];
  int m_cnt [2];
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  hazard_controller #(.MC_LATENCY(4), .CNT_W(16)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_src1_D(src1), .i_src2_D(src2), .i_Write_Reg_E(wreg),
    .i_MemRead_E(memrd), .i_branch_taken_E(br), .i_mc_start_E(mcs), .i_clear_stats(clr),
    .o_stall_F(sf[0]), .o_stall_D(sd[0]), .o_stall_E(se[0]), .o_flush_D(fd[0]),
    .o_flush_E(fe[0]), .o_flush_M(fm[0]), .o_mc_busy(busy[0]), .o_mc_done(done[0]),
    .o_stall_cycles(cnt_a)
  );

  hazard_controller #(.MC_LATENCY(1), .CNT_W(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_src1_D(src1), .i_src2_D(src2), .i_Write_Reg_E(wreg),
    .i_MemRead_E(memrd), .i_branch_taken_E(br), .i_mc_start_E(mcs), .i_clear_stats(clr),
    .o_stall_F(sf[1]), .o_stall_D(sd[1]), .o_stall_E(se[1]), .o_flush_D(fd[1]),
    .o_flush_E(fe[1]), .o_flush_M(fm[1]), .o_mc_busy(busy[1]), .o_mc_done(done[1]),
    .o_stall_cycles(cnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit order {stall_F, stall_D, stall_E, flush_D, flush_E, flush_M, busy, done}.
  function automatic logic [7:0] dut_ctrl(input int k);
    return {sf[k], sd[k], se[k], fd[k], fe[k], fm[k], busy[k], done[k]};
  endfunction

  // m_age counts how many cycles the current multi-cycle op has already spent in E.
  task automatic model_eval(input int k, output logic [7:0] exp_o, output int nage);
    int  lat;
    bit  lu;
    lat   = (k == 0) ? 4 : 1;
    exp_o = 8'h00;
    nage  = 0;
    lu    = memrd && (wreg != 0) && ((src1 == wreg) || (src2 == wreg));
    if (rst) begin
      exp_o = 8'h00;
    end else if (m_age[k] > 0) begin
      if (m_age[k] + 1 < lat) begin
        exp_o = 8'b1110_0110;
        nage  = m_age[k] + 1;
      end else begin
        exp_o = 8'b0000_0011;
      end
    end else begin
      if (mcs && lat == 1) exp_o[0] = 1'b1;
      if (br) exp_o[4:3] = 2'b11;
      else if (mcs && lat > 1) begin
        exp_o = exp_o | 8'b1110_0110;
        nage  = 1;
      end else if (lu) exp_o = exp_o | 8'b1100_1000;
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      for (int k = 0; k < 2; k++) begin
        logic [7:0] e;
        int         na, maxc;
        model_eval(k, e, na);
        maxc = (k == 0) ? 65535 : 15;
        chk((k == 0) ? "ctrl_a" : "ctrl_b", {24'h0, dut_ctrl(k)}, {24'h0, e});
        chk((k == 0) ? "cnt_a" : "cnt_b", (k == 0) ? {16'h0, cnt_a} : {28'h0, cnt_b},
            m_cnt[k]);
        m_age[k] = na;
        if (rst || clr) m_cnt[k] = 0;
        else if (e[7] && m_cnt[k] < maxc) m_cnt[k] = m_cnt[k] + 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    memrd = 0; br = 0; mcs = 0; clr = 0; src1 = 0; src2 = 0; wreg = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_age = '{0, 0};
    m_cnt = '{0, 0};
    model_on = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset_ctrl_a", {24'h0, dut_ctrl(0)}, 32'h0);
    chk("reset_cnt_a", {16'h0, cnt_a}, 32'd0);

    // Load-use on src2
    cyc();
    memrd = 1; wreg = 5'd5; src2 = 5'd5; src1 = 5'd1;
    @(negedge clk);
    chk("lu_ctrl", {24'h0, dut_ctrl(0)}, 32'b1100_1000);
    cyc();
    memrd = 0;
    @(negedge clk);
    chk("lu_after_ctrl", {24'h0, dut_ctrl(0)}, 32'h0);
    chk("lu_after_cnt", {16'h0, cnt_a}, 32'd1);

    // $0 destination and non-matching sources
    cyc();
    memrd = 1; wreg = 5'd0; src1 = 5'd0; src2 = 5'd3;
    @(negedge clk);
    chk("zero_reg_stall", {31'h0, sf[0]}, 32'd0);
    cyc();
    wreg = 5'd7; src1 = 5'd6; src2 = 5'd8;
    @(negedge clk);
    chk("nomatch_stall", {31'h0, sf[0]}, 32'd0);

    // Branch over a simultaneous load-use
    cyc();
    wreg = 5'd7; src1 = 5'd7; br = 1;
    @(negedge clk);
    chk("br_ctrl", {24'h0, dut_ctrl(0)}, 32'b0001_1000);
    cyc();
    idle_inputs();
    @(negedge clk);
    chk("br_cnt", {16'h0, cnt_a}, 32'd1);

    // Two back-to-back 4-cycle ops
    for (int c = 1; c <= 8; c++) begin
      cyc();
      mcs = 1;
      @(negedge clk);
      if (c % 4 == 0) chk("mc_done_cycle", {24'h0, dut_ctrl(0)}, 32'b0000_0011);
      else chk("mc_stall_cycle", {24'h0, dut_ctrl(0)}, 32'b1110_0110);
      chk("mc_lat1_done", {30'h0, sf[1], done[1]}, 32'b01);
      if (c == 5) chk("mc_cnt", {16'h0, cnt_a}, 32'd4);
    end
    cyc();
    mcs = 0;

    // Reset in cycle 2 of an op
    cyc();
    mcs = 1;
    cyc();
    rst = 1;
    @(negedge clk);
    chk("rst_mid_ctrl", {24'h0, dut_ctrl(0)}, 32'h0);
    cyc();
    rst = 0; mcs = 0;
    @(negedge clk);
    chk("rst_rel_ctrl", {24'h0, dut_ctrl(0)}, 32'h0);
    chk("rst_rel_cnt", {16'h0, cnt_a}, 32'd0);
    cyc();
    @(negedge clk);
    chk("rst_rel2_done", {31'h0, done[0]}, 32'd0);

    // Counter saturation, then clear against a stall
    for (int c = 0; c < 20; c++) begin
      cyc();
      memrd = 1; wreg = 5'd9; src1 = 5'd9;
    end
    cyc();
    clr = 1;
    @(negedge clk);
    chk("sat_cnt_a", {16'h0, cnt_a}, 32'd20);
    chk("sat_cnt_b", {28'h0, cnt_b}, 32'd15);
    chk("clr_stall", {31'h0, sf[0]}, 32'd1);
    cyc();
    idle_inputs();
    @(negedge clk);
    chk("clr_cnt_a", {16'h0, cnt_a}, 32'd0);
    chk("clr_cnt_b", {28'h0, cnt_b}, 32'd0);

    // Randomised traffic; the op request tends to stay high once raised
    for (int c = 0; c < 3000; c++) begin
      cyc();
      rst   = ($urandom_range(63) == 0);
      clr   = ($urandom_range(31) == 0);
      br    = ($urandom_range(7) == 0);
      mcs   = mcs ? ($urandom_range(3) != 0) : ($urandom_range(5) == 0);
      memrd = ($urandom_range(2) == 0);
      wreg  = 5'($urandom_range(3));
      src1  = 5'($urandom_range(3));
      src2  = 5'($urandom_range(3));
    end
    cyc();
    idle_inputs();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
